// File: rtl/spi_master_param_if.sv
`default_nettype none
// ============================================================================
// spi_master_param_if : command-side and SPI-pin bundle for spi_master_param.
// Optional feature macro: LOOPBACK_EN (adds the loopback select).
// Revision: 1.0
// ============================================================================
interface spi_master_param_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
`ifdef LOOPBACK_EN
    logic              loopback;
`endif
    logic              busy;
    logic [NUM_CS-1:0] cs_bar;
    logic              sclk;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_done;

`ifdef LOOPBACK_EN
    modport master (
        input  start, cpol, cpha, clk_div, cs_sel, tx_data, miso, loopback,
        output busy, cs_bar, sclk, mosi, rx_data, rx_valid, tx_done
    );
    modport slave (
        output start, cpol, cpha, clk_div, cs_sel, tx_data, miso, loopback,
        input  busy, cs_bar, sclk, mosi, rx_data, rx_valid, tx_done
    );
`else
    modport master (
        input  start, cpol, cpha, clk_div, cs_sel, tx_data, miso,
        output busy, cs_bar, sclk, mosi, rx_data, rx_valid, tx_done
    );
    modport slave (
        output start, cpol, cpha, clk_div, cs_sel, tx_data, miso,
        input  busy, cs_bar, sclk, mosi, rx_data, rx_valid, tx_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// spi_master_param : N-chip-select, four-mode SPI master, config latched per frame.
// Optional feature macro: LOOPBACK_EN (receive path may sample internal mosi).
// Revision: 1.0
// ============================================================================
module spi_master_param #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_param_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic              cpha_q;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [NUM_CS-1:0] cs_dec;

    logic              busy_q;
    logic [NUM_CS-1:0] cs_q;
    logic              sclk_q;
    logic              mosi_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    logic              tick;
    logic              last_edge;
    logic              leading;
    logic              accept;
    logic              do_edge;
    logic              finish;
    logic              sample_en;
    logic              drive_en;
    logic              rx_bit;

`ifdef LOOPBACK_EN
    logic              loop_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            loop_q <= 1'b0;
        end else if (accept) begin
            loop_q <= bus.loopback;
        end
    end

    assign rx_bit = loop_q ? mosi_q : bus.miso;
`else
    assign rx_bit = bus.miso;
`endif

    // Out-of-range cs_sel matches no index, so every select stays high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus.cs_sel == CS_W'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_edge   = 1'b0;
        finish    = 1'b0;
        tick      = (cnt == '0);
        last_edge = (edge_cnt == LAST_EDGE);
        leading   = ~edge_cnt[0];
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    do_edge   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    do_edge = 1'b1;
                    if (last_edge) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge drives.
        sample_en = do_edge & (leading ^ cpha_q);
        drive_en  = do_edge & ~(leading ^ cpha_q) & ~last_edge;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= '0;
            cnt        <= '0;
            cpha_q     <= 1'b0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            busy_q     <= 1'b0;
            cs_q       <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q <= bus.cpol;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        div_q    <= bus.clk_div;
                        cnt      <= bus.clk_div;
                        cpha_q   <= bus.cpha;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        busy_q   <= 1'b1;
                        cs_q     <= cs_dec;
                        // cpha=0 presents the MSB during setup; the register then holds the rest.
                        if (bus.cpha) begin
                            tx_sr <= bus.tx_data;
                        end else begin
                            tx_sr  <= {bus.tx_data[DATA_W-2:0], 1'b0};
                            mosi_q <= bus.tx_data[DATA_W-1];
                        end
                    end
                end
                default: begin
                    cnt <= tick ? div_q : cnt - 1'b1;
                    if (do_edge) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (drive_en) begin
                        mosi_q <= tx_sr[DATA_W-1];
                        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                    if (sample_en) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                    end
                    if (finish) begin
                        busy_q     <= 1'b0;
                        cs_q       <= '1;
                        mosi_q     <= 1'b0;
                        rx_data_q  <= rx_sr;
                        rx_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.cs_bar   = cs_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_done  = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// tb_spi_master_param : directed frames against a mode-aware SPI slave, scoreboard checked.
// Revision: 1.0
// ============================================================================
module tb_spi_master_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_param_if #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) bus ();
    spi_master_param_if #(.DATA_W(16), .NUM_CS(6), .DIV_W(8)) bus6 ();

    spi_master_param #(.DATA_W(16), .NUM_CS(4), .DIV_W(8)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    spi_master_param #(.DATA_W(16), .NUM_CS(6), .DIV_W(8)) u_dut6 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus6)
    );

    typedef struct {
        logic [15:0] rx;
        logic [15:0] mo;
        logic [3:0]  cs;
        int          cyc;
        int          half;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Slave model configuration, written by the stimulus process only
    logic        s_cpol = 1'b0;
    logic        s_cpha = 1'b0;
    logic [15:0] s_word = 16'h0000;

    logic        s_act  = 1'b0;
    logic        s_prev = 1'b0;
    logic [15:0] s_tx   = 16'h0000;
    logic [15:0] s_rx   = 16'h0000;

    // Mode-aware slave: presents its word MSB first, captures mosi on its sample edges.
    always @(negedge clk) begin
        if (!rst_n || (&bus.cs_bar)) begin
            s_act    <= 1'b0;
            bus.miso <= 1'b0;
        end else if (!s_act) begin
            s_act    <= 1'b1;
            s_rx     <= 16'h0000;
            s_tx     <= s_cpha ? s_word : {s_word[14:0], 1'b0};
            bus.miso <= ~s_cpha & s_word[15];
        end else if (bus.sclk != s_prev) begin
            if ((bus.sclk != s_cpol) ^ s_cpha) begin
                s_rx <= {s_rx[14:0], bus.mosi};
            end else begin
                bus.miso <= s_tx[15];
                s_tx     <= {s_tx[14:0], 1'b0};
            end
        end
        s_prev <= bus.sclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic       pb = 1'b0;
        logic       ps = 1'b0;
        int         since = 0, edges = 0, bcnt = 0, ccnt = 0, iv = 0;
        int         iv_min = 0, iv_max = 0;
        logic       csvar = 1'b0;
        logic [3:0] cs0 = 4'hF;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0;
                ps = bus.sclk;
                continue;
            end
            if (bus.busy && !pb) begin
                since  = 0;
                edges  = 0;
                bcnt   = 1;
                cs0    = bus.cs_bar;
                csvar  = 1'b0;
                ccnt   = (bus.cs_bar != 4'hF) ? 1 : 0;
                iv_min = 1000000;
                iv_max = 0;
            end else if (bus.busy) begin
                bcnt++;
                if (bus.cs_bar != 4'hF) ccnt++;
                if (bus.cs_bar != cs0) csvar = 1'b1;
                if (bus.sclk != ps) begin
                    iv = since + 1;
                    if (iv < iv_min) iv_min = iv;
                    if (iv > iv_max) iv_max = iv;
                    since = 0;
                    edges++;
                end else begin
                    since++;
                end
            end
            if (bus.rx_valid || bus.tx_done) begin
                chk("tx_done_with_rx_valid", {31'd0, bus.tx_done}, {31'd0, bus.rx_valid});
                if (bus.rx_valid) begin
                    chk("rx_valid_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rx_data", bus.rx_data, e.rx);
                        chk("slave_saw_mosi", s_rx, e.mo);
                        chk("cs_bar_frame", cs0, e.cs);
                        chk("cs_bar_stable", csvar, 0);
                        chk("busy_cycles", bcnt, e.cyc);
                        chk("cs_low_cycles", ccnt, e.cyc);
                        chk("sclk_edges", edges, 32);
                        chk("half_period_min", iv_min, e.half);
                        chk("half_period_max", iv_max, e.half);
                    end
                end
            end
            pb = bus.busy;
            ps = bus.sclk;
        end
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (bus.busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({nm, "_idle"}, bus.busy, 0);
    endtask

    task automatic push_exp(input logic [7:0] dv, input logic [1:0] cs,
                            input logic [15:0] tx, input logic [15:0] erx);
        exp_t e;
        e.rx   = erx;
        e.mo   = tx;
        e.cs   = ~(4'b0001 << cs);
        e.cyc  = 33 * (int'(dv) + 1);
        e.half = int'(dv) + 1;
        exp_q.push_back(e);
    endtask

    task automatic setup_cfg(input logic cp, input logic ch, input logic [7:0] dv,
                             input logic [1:0] cs, input logic [15:0] tx, input logic [15:0] sw);
        s_cpol      = cp;
        s_cpha      = ch;
        s_word      = sw;
        bus.cpol    = cp;
        bus.cpha    = ch;
        bus.clk_div = dv;
        bus.cs_sel  = cs;
        bus.tx_data = tx;
    endtask

    // One frame from idle; config inputs are scrambled mid-frame to show they were latched.
    task automatic frame(input string nm, input logic cp, input logic ch, input logic [7:0] dv,
                         input logic [1:0] cs, input logic [15:0] tx, input logic [15:0] sw,
                         input logic [15:0] erx);
        setup_cfg(cp, ch, dv, cs, tx, sw);
        push_exp(dv, cs, tx, erx);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.tx_data = ~tx;
        bus.cpha    = ~ch;
        bus.cpol    = ~cp;
        bus.clk_div = 8'h07;
        bus.cs_sel  = ~cs;
        wait_idle(nm);
        bus.cpol = cp;
        repeat (2) @(negedge clk);
        chk({nm, "_sclk_idle"}, bus.sclk, cp);
    endtask

    task automatic frame6(input string nm, input logic [2:0] cs, input logic [5:0] ecs);
        int i = 0;
        bus6.cs_sel = cs;
        bus6.start  = 1'b1;
        @(negedge clk);
        bus6.start = 1'b0;
        repeat (5) @(negedge clk);
        chk({nm, "_cs_bar"}, bus6.cs_bar, ecs);
        while (!bus6.rx_valid && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk({nm, "_rx_valid"}, bus6.rx_valid, 1);
        @(negedge clk);
    endtask

    initial begin
        int i;
        int edges;
        logic prev;
        bus.start   = 1'b0;
        bus.cpol    = 1'b1;
        bus.cpha    = 1'b0;
        bus.clk_div = 8'h00;
        bus.cs_sel  = 2'd0;
        bus.tx_data = 16'h0000;
        bus6.start   = 1'b0;
        bus6.cpol    = 1'b0;
        bus6.cpha    = 1'b0;
        bus6.clk_div = 8'h00;
        bus6.cs_sel  = 3'd0;
        bus6.tx_data = 16'hC35A;
        bus6.miso    = 1'b0;
`ifdef LOOPBACK_EN
        bus.loopback  = 1'b0;
        bus6.loopback = 1'b0;
`endif
        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_cs_bar", bus.cs_bar, 4'hF);
        chk("reset_sclk", bus.sclk, 0);
        chk("reset_mosi", bus.mosi, 0);
        chk("reset_rx_data", bus.rx_data, 16'h0000);
        chk("reset_rx_valid", bus.rx_valid, 0);
        chk("reset_tx_done", bus.tx_done, 0);
        chk("reset_cs_bar6", bus6.cs_bar, 6'h3F);
        rst_n = 1'b1;
        bus.cpol = 1'b0;
        repeat (2) @(negedge clk);

        // Basic mode 0 frame with an independent slave word
        frame("mode0_f1f1", 1'b0, 1'b0, 8'd0, 2'd0, 16'hF1F1, 16'h000A, 16'h000A);

        // All four modes, divided clock, echoing slave
        frame("mode0_div3", 1'b0, 1'b0, 8'd3, 2'd1, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        frame("mode1_div3", 1'b0, 1'b1, 8'd3, 2'd1, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        frame("mode2_div3", 1'b1, 1'b0, 8'd3, 2'd1, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        frame("mode3_div3", 1'b1, 1'b1, 8'd3, 2'd1, 16'hA5C3, 16'hA5C3, 16'hA5C3);

        // Chip select 2 only
        frame("cs2", 1'b0, 1'b1, 8'd1, 2'd2, 16'h8001, 16'h7FFE, 16'h7FFE);

        // Six-select build: in range and out of range
        frame6("cs6_sel5", 3'd5, 6'b011111);
        frame6("cs6_sel7", 3'd7, 6'b111111);

        // Start pulsed mid-frame is ignored
        setup_cfg(1'b0, 1'b0, 8'd0, 2'd3, 16'h3C3C, 16'h5A5A);
        push_exp(8'd0, 2'd3, 16'h3C3C, 16'h5A5A);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("midstart");
        repeat (3) @(negedge clk);
        chk("midstart_not_queued", bus.busy, 0);

        // Start held through rx_valid: back-to-back frames
        setup_cfg(1'b0, 1'b0, 8'd0, 2'd0, 16'h9669, 16'h0FF0);
        push_exp(8'd0, 2'd0, 16'h9669, 16'h0FF0);
        push_exp(8'd0, 2'd0, 16'h9669, 16'h0FF0);
        bus.start = 1'b1;
        i = 0;
        @(negedge clk);
        while (!bus.rx_valid && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("b2b_first_done", bus.rx_valid, 1);
        @(negedge clk);
        chk("b2b_cs_bar", bus.cs_bar, 4'b1110);
        chk("b2b_busy", bus.busy, 1);
        bus.start = 1'b0;
        wait_idle("b2b");
        repeat (2) @(negedge clk);

        // Reset after the 10th SCLK edge aborts the frame silently
        setup_cfg(1'b1, 1'b0, 8'd1, 2'd1, 16'hBEEF, 16'hFFFF);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev  = bus.sclk;
        edges = 0;
        i     = 0;
        while (edges < 10 && i < 500) begin
            @(negedge clk);
            if (bus.sclk != prev) edges++;
            prev = bus.sclk;
            i++;
        end
        chk("abort_edges_seen", edges, 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cs_bar", bus.cs_bar, 4'hF);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rx_data", bus.rx_data, 16'h0000);
        chk("abort_rx_valid", bus.rx_valid, 0);
        chk("abort_tx_done", bus.tx_done, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", bus.busy, 0);

`ifdef LOOPBACK_EN
        bus.loopback = 1'b1;
        frame("loop_on", 1'b0, 1'b0, 8'd0, 2'd0, 16'h1234, 16'h0000, 16'h1234);
        bus.loopback = 1'b0;
        frame("loop_off", 1'b0, 1'b0, 8'd0, 2'd0, 16'h1234, 16'h0000, 16'h0000);
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
